// File: rtl/snow64_ext_mem_ctrl.sv
// Bridges the CPU external data-access port to Snow64MainMem: one request at a time,
// issued to memory, waited out for the read latency, and answered with a one-cycle valid pulse.
module snow64_ext_mem_ctrl #(
    parameter int ADDR_WIDTH     = 59,
    parameter int DATA_WIDTH     = 256,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_cpu_req,
    input  logic                  in_cpu_access_type,
    input  logic [ADDR_WIDTH-1:0] in_cpu_addr,
    input  logic [DATA_WIDTH-1:0] in_cpu_data,
    output logic                  out_cpu_valid,
    output logic [DATA_WIDTH-1:0] out_cpu_data,
    output logic                  out_cpu_busy,
    output logic                  out_overrun,
    output logic [15:0]           out_txn_count,
    output logic                  out_mem_req_wr,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [DATA_WIDTH-1:0] out_mem_data,
    input  logic [DATA_WIDTH-1:0] in_mem_data
);

    if ((MEM_RD_LATENCY < 1) || (MEM_RD_LATENCY > 15)) begin : g_bad_latency
        $error("snow64_ext_mem_ctrl: MEM_RD_LATENCY must be in 1..15");
    end

    localparam logic [3:0] LAT_CNT = 4'(MEM_RD_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  type_q, type_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic [15:0]           txn_count_q, txn_count_d;
    logic                  mem_wr_q, mem_wr_d;

    // Next-state and next-output computation for the request FSM.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        cpu_data_d  = cpu_data_q;
        overrun_d   = overrun_q;
        txn_count_d = txn_count_q;
        mem_wr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_cpu_req) begin
                    type_d   = in_cpu_access_type;
                    addr_d   = in_cpu_addr;
                    wdata_d  = in_cpu_data;
                    mem_wr_d = in_cpu_access_type;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (type_q) begin
                    valid_d     = 1'b1;
                    cpu_data_d  = {DATA_WIDTH{1'b0}};
                    txn_count_d = txn_count_q + 16'd1;
                    state_d     = ST_RESP;
                end else begin
                    // Memory registers the address at the end of ISSUE; data shows up
                    // MEM_RD_LATENCY cycles later, so count that many WAIT cycles.
                    cnt_d   = LAT_CNT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    cnt_d       = 4'd0;
                    valid_d     = 1'b1;
                    cpu_data_d  = in_mem_data;
                    txn_count_d = txn_count_q + 16'd1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && in_cpu_req) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset wins over any same-cycle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            type_q      <= 1'b0;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= {DATA_WIDTH{1'b0}};
            cnt_q       <= 4'd0;
            valid_q     <= 1'b0;
            cpu_data_q  <= {DATA_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            txn_count_q <= 16'd0;
            mem_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            cpu_data_q  <= cpu_data_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            txn_count_q <= txn_count_d;
            mem_wr_q    <= mem_wr_d;
        end
    end

    // The write strobe is gated by rst directly so a reset during ISSUE blocks the write.
    assign out_mem_req_wr = mem_wr_q & ~rst;
    assign out_mem_addr   = addr_q;
    assign out_mem_data   = wdata_q;
    assign out_cpu_valid  = valid_q;
    assign out_cpu_data   = cpu_data_q;
    assign out_cpu_busy   = busy_q;
    assign out_overrun    = overrun_q;
    assign out_txn_count  = txn_count_q;

endmodule

// File: tb/tb_snow64_ext_mem_ctrl.sv
// Directed bench: two controllers (read latency 1 and 4) share CPU stimulus, each with its own memory model.
module tb_snow64_ext_mem_ctrl;

    localparam int AW = 59;
    localparam int DW = 256;
    localparam int ZW = 16 + AW + 2 * DW;
    localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [DW-1:0] PAT_5A = {32{8'h5A}};
    localparam logic [DW-1:0] JUNK   = {8{32'hDEAD_BEEF}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req, typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;

    logic          out_cpu_valid_a, out_cpu_busy_a, out_overrun_a, out_mem_req_wr_a;
    logic [DW-1:0] out_cpu_data_a, out_mem_data_a, in_mem_data_a;
    logic [AW-1:0] out_mem_addr_a;
    logic [15:0]   out_txn_count_a;
    logic          out_cpu_valid_b, out_cpu_busy_b, out_overrun_b, out_mem_req_wr_b;
    logic [DW-1:0] out_cpu_data_b, out_mem_data_b, in_mem_data_b;
    logic [AW-1:0] out_mem_addr_b;
    logic [15:0]   out_txn_count_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem [16];

    snow64_ext_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .in_cpu_req(req), .in_cpu_access_type(typ),
        .in_cpu_addr(addr), .in_cpu_data(wdata),
        .out_cpu_valid(out_cpu_valid_a), .out_cpu_data(out_cpu_data_a),
        .out_cpu_busy(out_cpu_busy_a), .out_overrun(out_overrun_a),
        .out_txn_count(out_txn_count_a), .out_mem_req_wr(out_mem_req_wr_a),
        .out_mem_addr(out_mem_addr_a), .out_mem_data(out_mem_data_a),
        .in_mem_data(in_mem_data_a));

    snow64_ext_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_RD_LATENCY(4)) dut_b (
        .clk(clk), .rst(rst), .in_cpu_req(req), .in_cpu_access_type(typ),
        .in_cpu_addr(addr), .in_cpu_data(wdata),
        .out_cpu_valid(out_cpu_valid_b), .out_cpu_data(out_cpu_data_b),
        .out_cpu_busy(out_cpu_busy_b), .out_overrun(out_overrun_b),
        .out_txn_count(out_txn_count_b), .out_mem_req_wr(out_mem_req_wr_b),
        .out_mem_addr(out_mem_addr_b), .out_mem_data(out_mem_data_b),
        .in_mem_data(in_mem_data_b));

    // Memory models: the address is taken on the first busy cycle (ISSUE); read data is
    // valid only exactly L cycles later, junk at every other time.
    logic          busy_prev_a = 1'b0, busy_prev_b = 1'b0;
    logic          pv_a = 1'b0;
    logic [DW-1:0] pd_a;
    logic [3:0]    pv_b = 4'b0000;
    logic [DW-1:0] pd_b [4];

    always @(posedge clk) begin
        busy_prev_a <= out_cpu_busy_a;
        pv_a        <= out_cpu_busy_a & ~busy_prev_a;
        pd_a        <= mem[out_mem_addr_a[3:0]];
        busy_prev_b <= out_cpu_busy_b;
        pv_b        <= {pv_b[2:0], out_cpu_busy_b & ~busy_prev_b};
        pd_b[0]     <= mem[out_mem_addr_b[3:0]];
        pd_b[1]     <= pd_b[0];
        pd_b[2]     <= pd_b[1];
        pd_b[3]     <= pd_b[2];
    end

    assign in_mem_data_a = pv_a ? pd_a : JUNK;
    assign in_mem_data_b = pv_b[3] ? pd_b[3] : JUNK;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; typ = 1'b1; addr = 59'h7; wdata = JUNK;
        step(); step();
        rst = 1'b0; req = 1'b0;
        step();
        n_cmp++;
        if ({out_cpu_valid_a, out_cpu_busy_a, out_overrun_a, out_mem_req_wr_a} !== 4'b0000) begin
            n_err++; $display("FAIL rst_flags_a: got %b want 0000", {out_cpu_valid_a, out_cpu_busy_a, out_overrun_a, out_mem_req_wr_a});
        end
        n_cmp++;
        if ({out_cpu_valid_b, out_cpu_busy_b, out_overrun_b, out_mem_req_wr_b} !== 4'b0000) begin
            n_err++; $display("FAIL rst_flags_b: got %b want 0000", {out_cpu_valid_b, out_cpu_busy_b, out_overrun_b, out_mem_req_wr_b});
        end
        n_cmp++;
        if ({out_txn_count_a, out_mem_addr_a, out_mem_data_a, out_cpu_data_a} !== {ZW{1'b0}}) begin
            n_err++; $display("FAIL rst_values_a: got %h want 0", {out_txn_count_a, out_mem_addr_a, out_mem_data_a, out_cpu_data_a});
        end
        n_cmp++;
        if ({out_txn_count_b, out_mem_addr_b, out_mem_data_b, out_cpu_data_b} !== {ZW{1'b0}}) begin
            n_err++; $display("FAIL rst_values_b: got %h want 0", {out_txn_count_b, out_mem_addr_b, out_mem_data_b, out_cpu_data_b});
        end
    endtask

    task automatic test_write();
        req = 1'b1; typ = 1'b1; addr = 59'h10; wdata = PAT_A5;
        step();
        req = 1'b0; typ = 1'b0; addr = 59'h7FF; wdata = JUNK;
        n_cmp++;
        if ({out_mem_req_wr_a, out_cpu_busy_a, out_cpu_valid_a, out_mem_req_wr_b, out_cpu_busy_b, out_cpu_valid_b} !== 6'b110110) begin
            n_err++; $display("FAIL wr_issue_flags: got %b want 110110", {out_mem_req_wr_a, out_cpu_busy_a, out_cpu_valid_a, out_mem_req_wr_b, out_cpu_busy_b, out_cpu_valid_b});
        end
        n_cmp++;
        if (out_mem_addr_a !== 59'h10 || out_mem_data_a !== PAT_A5) begin
            n_err++; $display("FAIL wr_issue_addr_data: got %h / %h want 10 / %h", out_mem_addr_a, out_mem_data_a, PAT_A5);
        end
        step();
        n_cmp++;
        if ({out_mem_req_wr_a, out_cpu_busy_a, out_cpu_valid_a, out_mem_req_wr_b, out_cpu_busy_b, out_cpu_valid_b} !== 6'b011011) begin
            n_err++; $display("FAIL wr_resp_flags: got %b want 011011", {out_mem_req_wr_a, out_cpu_busy_a, out_cpu_valid_a, out_mem_req_wr_b, out_cpu_busy_b, out_cpu_valid_b});
        end
        n_cmp++;
        if (out_cpu_data_a !== {DW{1'b0}} || out_txn_count_a !== 16'd1 || out_txn_count_b !== 16'd1) begin
            n_err++; $display("FAIL wr_resp_data_count: got data %h cnt %0d/%0d want 0 cnt 1/1", out_cpu_data_a, out_txn_count_a, out_txn_count_b);
        end
        step();
        n_cmp++;
        if ({out_cpu_busy_a, out_cpu_valid_a, out_cpu_busy_b, out_cpu_valid_b} !== 4'b0000) begin
            n_err++; $display("FAIL wr_idle_flags: got %b want 0000", {out_cpu_busy_a, out_cpu_valid_a, out_cpu_busy_b, out_cpu_valid_b});
        end
    endtask

    task automatic test_read();
        req = 1'b1; typ = 1'b0; addr = 59'h10; wdata = JUNK;
        for (int k = 1; k <= 7; k++) begin
            step();
            req = 1'b0; addr = 59'h5;
            if (k == 1) begin
                n_cmp++;
                if (out_mem_addr_a !== 59'h10 || out_mem_addr_b !== 59'h10) begin
                    n_err++; $display("FAIL rd_issue_addr: got %h/%h want 10", out_mem_addr_a, out_mem_addr_b);
                end
            end
            n_cmp++;
            if ({out_cpu_valid_a, out_cpu_busy_a, out_mem_req_wr_a} !== {k == 3, k <= 3, 1'b0}) begin
                n_err++; $display("FAIL rd_flags_a k=%0d: got %b want %b", k, {out_cpu_valid_a, out_cpu_busy_a, out_mem_req_wr_a}, {k == 3, k <= 3, 1'b0});
            end
            n_cmp++;
            if ({out_cpu_valid_b, out_cpu_busy_b, out_mem_req_wr_b} !== {k == 6, k <= 6, 1'b0}) begin
                n_err++; $display("FAIL rd_flags_b k=%0d: got %b want %b", k, {out_cpu_valid_b, out_cpu_busy_b, out_mem_req_wr_b}, {k == 6, k <= 6, 1'b0});
            end
            n_cmp++;
            if (out_cpu_data_a !== ((k >= 3) ? PAT_A5 : {DW{1'b0}}) || out_txn_count_a !== ((k >= 3) ? 16'd2 : 16'd1)) begin
                n_err++; $display("FAIL rd_data_a k=%0d: got %h cnt %0d", k, out_cpu_data_a, out_txn_count_a);
            end
            n_cmp++;
            if (out_cpu_data_b !== ((k >= 6) ? PAT_A5 : {DW{1'b0}}) || out_txn_count_b !== ((k >= 6) ? 16'd2 : 16'd1)) begin
                n_err++; $display("FAIL rd_data_b k=%0d: got %h cnt %0d", k, out_cpu_data_b, out_txn_count_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_a;
        int done_b;
        logic exp_va, exp_vb;
        done_a = 0; done_b = 0;
        req = 1'b1; typ = 1'b0; addr = 59'd0;
        for (int c = 1; c <= 26; c++) begin
            step();
            exp_va = ((c % 4) == 3) && (c <= 19);
            exp_vb = ((c % 7) == 6) && (c <= 20);
            n_cmp++;
            if (out_cpu_valid_a !== exp_va || out_cpu_valid_b !== exp_vb) begin
                n_err++; $display("FAIL b2b_valid c=%0d: got %b%b want %b%b", c, out_cpu_valid_a, out_cpu_valid_b, exp_va, exp_vb);
            end
            if (out_cpu_valid_a) done_a++;
            if (out_cpu_valid_b) done_b++;
            if (exp_va) begin
                n_cmp++;
                if (out_cpu_data_a !== mem[(c - 3) % 16]) begin
                    n_err++; $display("FAIL b2b_data_a c=%0d: got %h want %h", c, out_cpu_data_a, mem[(c - 3) % 16]);
                end
            end
            if (exp_vb) begin
                n_cmp++;
                if (out_cpu_data_b !== mem[(c - 6) % 16]) begin
                    n_err++; $display("FAIL b2b_data_b c=%0d: got %h want %h", c, out_cpu_data_b, mem[(c - 6) % 16]);
                end
            end
            req = (c < 20); addr = AW'(c);
        end
        n_cmp++;
        if (done_a != 5 || done_b != 3) begin
            n_err++; $display("FAIL b2b_completions: got %0d/%0d want 5/3", done_a, done_b);
        end
        n_cmp++;
        if ({out_overrun_a, out_overrun_b} !== 2'b11 || out_txn_count_a !== 16'd7 || out_txn_count_b !== 16'd5) begin
            n_err++; $display("FAIL b2b_overrun_count: got %b cnt %0d/%0d want 11 cnt 7/5", {out_overrun_a, out_overrun_b}, out_txn_count_a, out_txn_count_b);
        end
    endtask

    task automatic test_reset_mid();
        // Reset while dut_b waits on a read (dut_a is already answering that cycle).
        req = 1'b1; typ = 1'b0; addr = 59'h10;
        step(); req = 1'b0;
        step(); step();
        n_cmp++;
        if ({out_cpu_valid_a, out_cpu_valid_b, out_cpu_busy_b} !== 3'b101) begin
            n_err++; $display("FAIL rstw_pre: got %b want 101", {out_cpu_valid_a, out_cpu_valid_b, out_cpu_busy_b});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({out_cpu_valid_a, out_cpu_busy_a, out_cpu_valid_b, out_cpu_busy_b, out_overrun_a, out_overrun_b} !== 6'b000000
                || out_txn_count_a !== 16'd0 || out_txn_count_b !== 16'd0) begin
                n_err++; $display("FAIL rstw_after k=%0d: got %b cnt %0d/%0d want 000000 cnt 0/0", k,
                    {out_cpu_valid_a, out_cpu_busy_a, out_cpu_valid_b, out_cpu_busy_b, out_overrun_a, out_overrun_b}, out_txn_count_a, out_txn_count_b);
            end
            step();
        end
        // Reset during ISSUE of a write must suppress the memory write.
        req = 1'b1; typ = 1'b1; addr = 59'h20; wdata = PAT_5A;
        step();
        req = 1'b0; rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_mem_req_wr_a, out_mem_req_wr_b} !== 2'b00) begin
            n_err++; $display("FAIL rsti_memwr: got %b want 00", {out_mem_req_wr_a, out_mem_req_wr_b});
        end
        step();
        rst = 1'b0;
        n_cmp++;
        if ({out_cpu_valid_a, out_cpu_busy_a, out_cpu_valid_b, out_cpu_busy_b, out_mem_req_wr_a} !== 5'b00000
            || out_txn_count_a !== 16'd0 || out_txn_count_b !== 16'd0) begin
            n_err++; $display("FAIL rsti_after: got %b cnt %0d/%0d want 00000 cnt 0/0",
                {out_cpu_valid_a, out_cpu_busy_a, out_cpu_valid_b, out_cpu_busy_b, out_mem_req_wr_a}, out_txn_count_a, out_txn_count_b);
        end
        // A fresh read is accepted straight away.
        req = 1'b1; typ = 1'b0; addr = 59'h23;
        step(); req = 1'b0;
        step(); step();
        n_cmp++;
        if (out_cpu_valid_a !== 1'b1 || out_cpu_data_a !== mem[3] || out_txn_count_a !== 16'd1) begin
            n_err++; $display("FAIL rst_new_rd_a: got v%b %h cnt %0d want v1 %h cnt 1", out_cpu_valid_a, out_cpu_data_a, out_txn_count_a, mem[3]);
        end
        step(); step(); step();
        n_cmp++;
        if (out_cpu_valid_b !== 1'b1 || out_cpu_data_b !== mem[3] || out_txn_count_b !== 16'd1) begin
            n_err++; $display("FAIL rst_new_rd_b: got v%b %h cnt %0d want v1 %h cnt 1", out_cpu_valid_b, out_cpu_data_b, out_txn_count_b, mem[3]);
        end
        step();
    endtask

    task automatic test_count_wrap();
        force dut_a.txn_count_q = 16'hFFFF;
        step();
        release dut_a.txn_count_q;
        n_cmp++;
        if (out_txn_count_a !== 16'hFFFF) begin
            n_err++; $display("FAIL wrap_preload: got %h want ffff", out_txn_count_a);
        end
        req = 1'b1; typ = 1'b1; addr = 59'h30; wdata = PAT_A5;
        step(); req = 1'b0;
        step();
        n_cmp++;
        if (out_cpu_valid_a !== 1'b1 || out_txn_count_a !== 16'h0000 || out_overrun_a !== 1'b0 || out_txn_count_b !== 16'd2) begin
            n_err++; $display("FAIL wrap_count: got v%b cnt %h ovr %b cnt_b %0d want v1 cnt 0000 ovr 0 cnt_b 2",
                out_cpu_valid_a, out_txn_count_a, out_overrun_a, out_txn_count_b);
        end
        step();
        n_cmp++;
        if (out_txn_count_a !== 16'h0000 || out_overrun_a !== 1'b0) begin
            n_err++; $display("FAIL wrap_hold: got cnt %h ovr %b want 0000 0", out_txn_count_a, out_overrun_a);
        end
    endtask

    initial begin
        for (int j = 0; j < 16; j++) begin
            mem[j] = {8{32'hC0DE_0000 | 32'(j)}};
        end
        mem[0] = PAT_A5;
        rst = 1'b1; req = 1'b0; typ = 1'b0; addr = '0; wdata = '0;
        step();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
